// File: rtl/emif_pkg.sv
// Shared types and constants for the EMIF asynchronous slave front end.
package emif_pkg;
  localparam int EMIF_A_W   = 22;
  localparam int EMIF_D_W   = 16;
  localparam int EMIF_DQM_W = 2;

  localparam logic [EMIF_D_W-1:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RELEASE = 2'd3
  } state_e;
endpackage

// File: rtl/emif_sync.sv
// Multi-stage synchroniser for one asynchronous active-low strobe; resets to inactive (1).
module emif_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic inclk0,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);
  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge inclk0) begin
    if (!rst_n) chain_q <= '1;
    else        chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
endmodule

// File: rtl/emif_async_slave.sv
// EMIF pin-side slave: synchronises DSP strobes and turns each access into one
// request/ack transaction on the internal register bus, stretching nWAIT meanwhile.
module emif_async_slave
  import emif_pkg::*;
#(
  parameter int                 ADDR_W      = 23,
  parameter int                 DATA_W      = 16,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 TIMEOUT     = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA    = ERR_DATA_DEF
) (
  input  logic                  inclk0,
  input  logic                  rst_n,
  input  logic                  EMIF_nCS3,
  input  logic                  EMIF_nCS4,
  input  logic                  EMIF_nWE,
  input  logic                  EMIF_nOE,
  input  logic [EMIF_DQM_W-1:0] EMIF_nDQM,
  input  logic [EMIF_A_W-1:0]   EMIF_A,
  input  logic [1:0]            EMIF_BA,
  input  logic [DATA_W-1:0]     EMIF_D_i,
  output logic [DATA_W-1:0]     EMIF_D_o,
  output logic                  EMIF_D_oe,
  output logic                  EMIF_nWAIT,
  output logic                  bus_cs,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [EMIF_DQM_W-1:0] bus_be,
  output logic                  bus_wr,
  output logic                  bus_rd,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [3:0] raw, syn;
  logic       ncs3_s, ncs4_s, nwe_s, noe_s, cs_n, wr_act, rd_act;

  assign raw = {EMIF_nOE, EMIF_nWE, EMIF_nCS4, EMIF_nCS3};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    emif_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .inclk0 (inclk0),
      .rst_n  (rst_n),
      .async_i(raw[i]),
      .sync_o (syn[i])
    );
  end

  assign {noe_s, nwe_s, ncs4_s, ncs3_s} = syn;
  assign cs_n   = ncs3_s & ncs4_s;
  assign wr_act = !cs_n && !nwe_s;
  assign rd_act = !cs_n && !noe_s;

  // BA[0] carries no meaning in 16-bit mode.
  logic unused_ba0;
  assign unused_ba0 = EMIF_BA[0];

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    nwait_q, nwait_d, doe_q, doe_d;
  logic                    wr_q, wr_d, rd_q, rd_d, err_q, err_d, cs_q, cs_d;
  logic [DATA_W-1:0]       do_q, do_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [EMIF_DQM_W-1:0]   be_q, be_d;

  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nwait_q <= 1'b1;
      doe_q   <= 1'b0;
      do_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nwait_q <= nwait_d;
      doe_q   <= doe_d;
      do_q    <= do_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nwait_d = nwait_q;
    doe_d   = doe_q;
    do_d    = do_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    cs_d    = cs_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        // Pins are latched raw here; DSP setup time guarantees they are stable.
        if (wr_act) begin
          state_d = WR_REQ;
          wr_d    = 1'b1;
          nwait_d = 1'b0;
          cnt_d   = '0;
          addr_d  = ADDR_W'({EMIF_A, EMIF_BA[1]});
          wdata_d = EMIF_D_i;
          be_d    = ~EMIF_nDQM;
          cs_d    = ncs3_s;
        end else if (rd_act) begin
          state_d = RD_REQ;
          rd_d    = 1'b1;
          nwait_d = 1'b0;
          doe_d   = 1'b1;
          cnt_d   = '0;
          addr_d  = ADDR_W'({EMIF_A, EMIF_BA[1]});
          cs_d    = ncs3_s;
        end
      end
      WR_REQ, RD_REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A late ack on the timeout cycle still wins over the error path.
        if (bus_ack) begin
          state_d = RELEASE;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          nwait_d = 1'b1;
          if (state_q == RD_REQ) do_d = bus_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RELEASE;
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          nwait_d = 1'b1;
          err_d   = 1'b1;
          if (state_q == RD_REQ) do_d = ERR_DATA;
        end
      end
      RELEASE: begin
        if (cs_n || (nwe_s && noe_s)) begin
          state_d = IDLE;
          doe_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign EMIF_D_o   = do_q;
  assign EMIF_D_oe  = doe_q;
  assign EMIF_nWAIT = nwait_q;
  assign bus_cs     = cs_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_be     = be_q;
  assign bus_wr     = wr_q;
  assign bus_rd     = rd_q;
  assign bus_err    = err_q;
endmodule

// File: tb/tb_emif_async_slave.sv
// Randomised bench for emif_async_slave: an access-timeline model predicts every output each cycle.
module tb_emif_async_slave;
  localparam int S  = 2;
  localparam int TO = 20;

  logic        inclk0 = 1'b0;
  logic        rst_n;
  logic        EMIF_nCS3, EMIF_nCS4, EMIF_nWE, EMIF_nOE;
  logic [1:0]  EMIF_nDQM, EMIF_BA;
  logic [21:0] EMIF_A;
  logic [15:0] EMIF_D_i, EMIF_D_o, bus_wdata, bus_rdata;
  logic        EMIF_D_oe, EMIF_nWAIT, bus_cs, bus_wr, bus_rd, bus_ack, bus_err;
  logic [22:0] bus_addr;
  logic [1:0]  bus_be;

  always #5 inclk0 = ~inclk0;

  emif_async_slave #(
    .ADDR_W(23), .DATA_W(16), .SYNC_STAGES(S), .TIMEOUT(TO), .ERR_DATA(16'hDEAD)
  ) dut (
    .inclk0(inclk0), .rst_n(rst_n),
    .EMIF_nCS3(EMIF_nCS3), .EMIF_nCS4(EMIF_nCS4), .EMIF_nWE(EMIF_nWE), .EMIF_nOE(EMIF_nOE),
    .EMIF_nDQM(EMIF_nDQM), .EMIF_A(EMIF_A), .EMIF_BA(EMIF_BA), .EMIF_D_i(EMIF_D_i),
    .EMIF_D_o(EMIF_D_o), .EMIF_D_oe(EMIF_D_oe), .EMIF_nWAIT(EMIF_nWAIT),
    .bus_cs(bus_cs), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  int compared = 0;
  int mismatched = 0;

  bit          chk_en = 1'b0;
  bit          exp_nwait, exp_wr, exp_rd, exp_doe, exp_err, exp_cs, chk_do;
  logic [22:0] exp_addr;
  logic [15:0] exp_wdata, exp_do;
  logic [1:0]  exp_be;

  logic [22:0] cap_addr;
  logic [15:0] cap_wdata, cap_do;
  logic [1:0]  cap_be;
  logic        cap_cs, prev_wr = 1'b0;
  int          err_seen = 0, wr_starts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge inclk0) begin
    if (chk_en) begin
      chk("nWAIT", EMIF_nWAIT, exp_nwait);
      chk("bus_wr", bus_wr, exp_wr);
      chk("bus_rd", bus_rd, exp_rd);
      chk("D_oe", EMIF_D_oe, exp_doe);
      chk("bus_err", bus_err, exp_err);
      if (exp_wr || exp_rd) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_cs", bus_cs, exp_cs);
        if (exp_wr) begin
          chk("bus_wdata", bus_wdata, exp_wdata);
          chk("bus_be", bus_be, exp_be);
        end
      end
      if (chk_do) chk("D_o", EMIF_D_o, exp_do);
      if (bus_wr || bus_rd) begin
        cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_cs = bus_cs;
      end
      if (EMIF_D_oe && EMIF_nWAIT) cap_do = EMIF_D_o;
      if (bus_err) err_seen++;
      if (bus_wr && !prev_wr) wr_starts++;
      prev_wr = bus_wr;
    end
  end

  task automatic pins_idle();
    EMIF_nCS3 = 1; EMIF_nCS4 = 1; EMIF_nWE = 1; EMIF_nOE = 1;
  endtask

  // kind: 0 write, 1 read, 2 both strobes (write must win). Entered #1 after a posedge.
  // Model: strobes seen after S edges, request at E=S+1, completion edge C,
  // RELEASE exit once both C passed and the released strobe has crossed the sync chain.
  task automatic access(input int kind, input bit cs_sel, input logic [21:0] a,
                        input logic [1:0] ba, input logic [15:0] d, input logic [1:0] dqm,
                        input int ack_d, input logic [15:0] rdat, input int hold,
                        input bit drop_cs, input int gap, input bit noise);
    int E, C, X;
    bit is_wr, acked;
    is_wr = (kind != 1);
    E     = S + 1;
    acked = (ack_d <= TO - 1);
    C     = acked ? E + ack_d + 1 : E + TO;
    X     = (C + 1 > hold + S + 1) ? C + 1 : hold + S + 1;
    EMIF_A = a; EMIF_BA = ba; EMIF_D_i = d; EMIF_nDQM = dqm;
    EMIF_nCS3 = cs_sel; EMIF_nCS4 = !cs_sel;
    EMIF_nWE = (kind == 1); EMIF_nOE = (kind == 0);
    bus_ack = noise && ($urandom_range(0, 3) == 0);
    for (int n = 1; n <= X + gap; n++) begin
      @(posedge inclk0);
      exp_nwait = !(n >= E && n < C);
      exp_wr    = is_wr && n >= E && n < C;
      exp_rd    = !is_wr && n >= E && n < C;
      exp_doe   = !is_wr && n >= E && n < X;
      exp_err   = !acked && n == C;
      chk_do    = !is_wr && n >= C && n < X;
      exp_do    = acked ? rdat : 16'hDEAD;
      exp_addr  = {a, ba[1]};
      exp_wdata = d;
      exp_be    = ~dqm;
      exp_cs    = cs_sel;
      #1;
      if (n >= E) begin
        EMIF_A = 22'($urandom); EMIF_BA = 2'($urandom);
        EMIF_D_i = 16'($urandom); EMIF_nDQM = 2'($urandom);
      end
      if (n == hold) begin
        EMIF_nWE = 1; EMIF_nOE = 1;
        if (drop_cs) begin EMIF_nCS3 = 1; EMIF_nCS4 = 1; end
      end
      bus_rdata = 16'($urandom);
      bus_ack   = 1'b0;
      if (acked && n == E + ack_d) begin
        bus_ack = 1'b1; bus_rdata = rdat;
      end else if (noise && (n < E || n >= C) && $urandom_range(0, 3) == 0) begin
        bus_ack = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, w0, k, ad, hd;
    rst_n = 0; pins_idle();
    EMIF_A = '0; EMIF_BA = '0; EMIF_D_i = '0; EMIF_nDQM = '0;
    bus_ack = 0; bus_rdata = '0;
    exp_nwait = 1; exp_wr = 0; exp_rd = 0; exp_doe = 0; exp_err = 0; chk_do = 0;
    repeat (3) @(posedge inclk0);
    #1;
    chk("rst nWAIT", EMIF_nWAIT, 1);
    chk("rst D_oe", EMIF_D_oe, 0);
    chk("rst D_o", EMIF_D_o, 0);
    chk("rst wr/rd/err", {bus_wr, bus_rd, bus_err}, 0);
    chk("rst addr", bus_addr, 0);
    chk("rst wdata/be/cs", {bus_wdata, bus_be, bus_cs}, 0);
    rst_n = 1;
    chk_en = 1;

    access(0, 0, 22'h000012, 2'b10, 16'hA5A5, 2'b00, 3, 16'h0, 20, 1, 2, 0);
    chk("wr addr literal", cap_addr, 23'h000025);
    chk("wr data literal", cap_wdata, 16'hA5A5);
    chk("wr be/cs literal", {cap_be, cap_cs}, 3'b110);

    access(1, 1, 22'h0ABCDE, 2'b00, 16'h0, 2'b00, 5, 16'h1234, 15, 1, 2, 0);
    chk("rd data literal", cap_do, 16'h1234);
    chk("rd cs literal", cap_cs, 1);

    e0 = err_seen;
    access(1, 0, 22'h000100, 2'b00, 16'h0, 2'b00, TO, 16'h0, 5, 1, 2, 0);
    chk("timeout err count", err_seen - e0, 1);
    chk("timeout data", cap_do, 16'hDEAD);

    access(0, 0, 22'h000033, 2'b00, 16'h5A5A, 2'b10, 1, 16'h0, 6, 1, 2, 1);
    chk("byte be literal", cap_be, 2'b01);

    access(2, 1, 22'h000044, 2'b10, 16'hC3C3, 2'b00, 2, 16'hFFFF, 6, 1, 2, 1);
    chk("both -> write data", cap_wdata, 16'hC3C3);

    e0 = err_seen;
    access(1, 0, 22'h000055, 2'b10, 16'h0, 2'b00, TO - 1, 16'h7777, 4, 0, 2, 0);
    chk("ack on timeout cycle: no err", err_seen - e0, 0);
    chk("ack on timeout cycle: data", cap_do, 16'h7777);

    w0 = wr_starts;
    access(0, 0, 22'h000010, 2'b00, 16'h1111, 2'b00, 0, 16'h0, 4, 1, 3, 0);
    access(0, 0, 22'h000020, 2'b10, 16'h2222, 2'b00, 0, 16'h0, 4, 1, 3, 0);
    chk("b2b write count", wr_starts - w0, 2);
    chk("b2b second addr", cap_addr, 23'h000041);

    // Reset in the middle of a read: outputs must drop on the very next edge.
    chk_en = 0;
    EMIF_nCS4 = 0; EMIF_nOE = 0;
    repeat (S + 3) @(posedge inclk0);
    #1;
    chk("pre-reset bus_rd", bus_rd, 1);
    rst_n = 0; pins_idle();
    @(posedge inclk0);
    #1;
    chk("mid-reset nWAIT/D_oe/rd", {EMIF_nWAIT, EMIF_D_oe, bus_rd}, 3'b100);
    @(posedge inclk0);
    #1;
    rst_n = 1;
    chk_en = 1;
    access(1, 1, 22'h000777, 2'b00, 16'h0, 2'b00, 2, 16'hBEEF, 5, 1, 2, 0);
    chk("post-reset read", cap_do, 16'hBEEF);

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      ad = (k == 0) ? TO : (k == 1) ? TO - 1 : $urandom_range(0, 6);
      hd = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(1, 30);
      access($urandom_range(0, 2), 1'($urandom), 22'($urandom), 2'($urandom),
             16'($urandom), 2'($urandom), ad, 16'($urandom), hd,
             1'($urandom), $urandom_range(1, 4), 1);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/emif_async_slave.md
Name: emif_async_slave

Overview:
Pin-side front end of the FPGA EMIF slave. It synchronises the asynchronous EMIF strobes from the DSP to inclk0 and decodes chip-select windows. It converts each EMIF access into a single-word request/acknowledge transaction on an internal register bus, holding nWAIT low until the bus completes. It sits directly between the EMIF pins, which reach it through the tristate at EMIF_top, and the downstream register file / peripheral decoder.

Parameters:
ADDR_W, 23, internal word-address width = {EMIF_A[21:0], EMIF_BA[1]}
DATA_W, 16, EMIF data width
SYNC_STAGES, 2, flip-flop stages on nCS3/nCS4/nWE/nOE (min 2)
TIMEOUT, 255, inclk0 cycles to wait for bus_ack before forced completion
ERR_DATA, 16'hDEAD, read data returned on timeout

Ports:
inclk0  in  1  system clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
EMIF_nCS3  in  1  chip select window 0, async
EMIF_nCS4  in  1  chip select window 1, async
EMIF_nWE  in  1  write strobe, async
EMIF_nOE  in  1  read strobe, async
EMIF_nDQM  in  2  byte masks, active low
EMIF_A  in  22  word address
EMIF_BA  in  2  bank address; BA[1] = address LSB in 16-bit mode
EMIF_D_i  in  16  data from pad
EMIF_D_o  out  16  data to pad
EMIF_D_oe  out  1  pad output enable; EMIF_top builds the inout
EMIF_nWAIT  out  1  low = extend strobe
bus_cs  out  1  0 = CS3 window, 1 = CS4 window
bus_addr  out  ADDR_W  request word address
bus_wdata  out  DATA_W  write data
bus_be  out  2  byte enables = ~nDQM
bus_wr  out  1  write request, held until ack
bus_rd  out  1  read request, held until ack
bus_rdata  in  DATA_W  read data, valid with bus_ack
bus_ack  in  1  one-cycle completion
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset, synchronous on rst_n low at a clock edge: state IDLE; EMIF_nWAIT=1; EMIF_D_oe=0; EMIF_D_o=0; bus_wr=bus_rd=bus_err=0; bus_addr, bus_wdata, bus_be, bus_cs = 0; sync chains preset to 1 (inactive).
- Strobe sync: cs_n = nCS3 & nCS4 after the SYNC_STAGES chain. wr_act = !cs_n & !nWE_s. rd_act = !cs_n & !nOE_s.
- FSM:
- IDLE: on wr_act, latch A/BA/D_i/nDQM/cs, drive nWAIT=0, go WR_REQ. Else on rd_act, latch address, drive nWAIT=0, EMIF_D_oe=1, go RD_REQ. If both are active, write wins.
- WR_REQ: bus_wr=1 until bus_ack. Then drop bus_wr, set nWAIT=1, go RELEASE.
- RD_REQ: bus_rd=1 until bus_ack. Then capture bus_rdata into EMIF_D_o, drop bus_rd, set nWAIT=1, go RELEASE.
- RELEASE: hold EMIF_D_oe and EMIF_D_o. Wait until cs_n=1 or both synced strobes are high. Then EMIF_D_oe=0, go IDLE.
- Latency: pin strobe to bus request = SYNC_STAGES+1 cycles. bus_ack to nWAIT high = 1 cycle.
- EMIF setup must be ≥ SYNC_STAGES+2 inclk0 cycles so nWAIT is low before the DSP samples it. This is a DSP config requirement.
- Address/data are latched once, on IDLE exit. Pin changes during the request are ignored.
- Timeout: a counter runs in WR_REQ/RD_REQ and clears on entry. At TIMEOUT with no ack:
- pulse bus_err for 1 cycle, drop the request, release nWAIT, and go RELEASE.
- For reads, EMIF_D_o=ERR_DATA.
- bus_ack is ignored outside WR_REQ/RD_REQ. An ack in the same cycle the timeout fires counts as a normal completion, with no bus_err.
- Strobe dropped before ack (DSP abort): the request stays until ack or timeout, then RELEASE exits immediately.
- Back-to-back accesses: a new access is accepted only from IDLE. The strobe must be seen inactive for ≥1 synced cycle between accesses, which RELEASE guarantees.
- Reset mid-transaction: immediate return to reset values. nWAIT goes high and D_oe goes low in the same cycle.

Decomposition:
- Package emif_pkg:
- state enum (IDLE, WR_REQ, RD_REQ, RELEASE);
- EMIF_A_W=22, EMIF_D_W=16, EMIF_DQM_W=2;
- ERR_DATA default.
- Sub-module emif_sync: parameterised SYNC_STAGES-deep flip-flop chain with reset-to-1. One instance per strobe.

Test Plan:
- Write: nCS3=0, A=22'h00012, BA=2'b10, D=16'hA5A5, nDQM=0, nWE low for 20 cycles; ack after 3 cycles -> bus_wr with bus_addr=23'h000025, bus_wdata=A5A5, bus_be=2'b11, bus_cs=0; nWAIT low from cycle 3 until 1 cycle after ack.
- Read: nCS4=0, nOE low, bus_rdata=16'h1234 with ack after 5 cycles -> bus_rd, bus_cs=1; EMIF_D_o=1234 with D_oe=1 until nOE high; nWAIT released 1 cycle after ack.
- Timeout: read with no bus_ack -> bus_err pulse at cycle TIMEOUT after entry; EMIF_D_o=DEAD; nWAIT high; return to IDLE when strobe ends.
- Byte write: nDQM=2'b10 -> bus_be=2'b01.
- Simultaneous nWE/nOE low -> write only.
- Reset mid-read, rst_n=0 while in RD_REQ -> next edge shows nWAIT=1, D_oe=0, bus_rd=0; a later access works normally.
- Back-to-back: two writes separated by 3 inactive cycles -> two distinct bus_wr requests with correct addresses, and no merge.
